// File: rtl/regfile_lane_sb.sv
// Parametrised register file with lane-granular writes, same-cycle write forwarding,
// branch-condition evaluation and a pending-load scoreboard that stalls decode.
module regfile_lane_sb #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int LANE_W     = 4,
  parameter int LSEL_W     = 2,
  parameter int IMM_W      = 4,
  parameter int MEM_REGS   = 4,
  parameter int TARGET_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_full,
  input  logic [LSEL_W-1:0] wr_lane,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [IMM_W-1:0]  imm,
  input  logic              immediate,
  input  logic              move,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] mem_sel,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] target,
  input  logic [3:0]        cmp_op,
  output logic              taken,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              stall
);
  localparam int NUM_REGS  = 2 ** ADDR_W;
  localparam int NUM_LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   fwd0, fwd1, fwd_mem;
  logic                hit0, hit1, hit_mem;

  // Value the written register will hold after this edge; out-of-range lanes match nothing.
  always_comb begin
    wr_word = regs[wr_addr];
    if (wr_full) begin
      wr_word = wr_data;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wr_lane == LSEL_W'(l)) wr_word[l*LANE_W +: LANE_W] = wr_data[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_word;
    end
  end

  // Set is applied after clear so a new load behind the retiring one stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_en)    pending[wr_addr]   <= 1'b0;
      if (pend_set) pending[pend_addr] <= 1'b1;
    end
  end

  assign hit0    = wr_en && (wr_addr == rd_addr0);
  assign hit1    = wr_en && (wr_addr == rd_addr1);
  assign hit_mem = wr_en && (wr_addr == mem_sel);

  assign fwd0    = hit0    ? wr_word : regs[rd_addr0];
  assign fwd1    = hit1    ? wr_word : regs[rd_addr1];
  assign fwd_mem = hit_mem ? wr_word : regs[mem_sel];

  assign rd_data0 = immediate ? DATA_W'(imm) : fwd0;
  assign rd_data1 = (immediate || move) ? '0 : fwd1;
  assign mem_data = (32'(mem_sel) < MEM_REGS) ? fwd_mem : '0;
  assign target   = regs[ADDR_W'(TARGET_IDX)];

  always_comb begin
    taken = 1'b0;
    case (cmp_op)
      4'd4:    taken = (rd_data0 >= rd_data1);
      4'd5:    taken = rd_data0[DATA_W-1];
      4'd6:    taken = (rd_data0 == '0);
      4'd7:    taken = (rd_data0 == rd_data1);
      4'd8:    taken = (rd_data0 != rd_data1);
      default: taken = 1'b0;
    endcase
  end

  // A same-cycle write to the operand's register supplies the data, so no stall for it.
  assign stall = (pending[rd_addr0] && !immediate && !hit0) ||
                 (pending[rd_addr1] && !immediate && !move && !hit1);

endmodule

// File: tb/tb_regfile_lane_sb.sv
// Directed table-driven bench for regfile_lane_sb plus a hand-written asynchronous reset sequence.
module tb_regfile_lane_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_full, immediate, move, pend_set;
  logic [2:0]  wr_addr, rd_addr0, rd_addr1, mem_sel, pend_addr;
  logic [1:0]  wr_lane;
  logic [15:0] wr_data;
  logic [3:0]  imm, cmp_op;
  logic [15:0] rd_data0, rd_data1, mem_data, target;
  logic        taken, stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_lane_sb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_full(wr_full),
    .wr_lane(wr_lane), .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .imm(imm), .immediate(immediate), .move(move), .rd_data0(rd_data0),
    .rd_data1(rd_data1), .mem_sel(mem_sel), .mem_data(mem_data), .target(target),
    .cmp_op(cmp_op), .taken(taken), .pend_set(pend_set), .pend_addr(pend_addr),
    .stall(stall)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic        wf;
    logic [1:0]  wl;
    logic [15:0] wd;
    logic [2:0]  ra0, ra1;
    logic [3:0]  im;
    logic        immd, mv;
    logic [2:0]  ms;
    logic [3:0]  cmp;
    logic        ps;
    logic [2:0]  pa;
    logic [15:0] e0, e1, em, et;
    logic        etk, est;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic we, input logic [2:0] wa, input logic wf, input logic [1:0] wl,
    input logic [15:0] wd, input logic [2:0] ra0, input logic [2:0] ra1,
    input logic [3:0] im, input logic immd, input logic mv, input logic [2:0] ms,
    input logic [3:0] cmp, input logic ps, input logic [2:0] pa,
    input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] em,
    input logic [15:0] et, input logic etk, input logic est);
    vec_t v;
    v.we = we; v.wa = wa; v.wf = wf; v.wl = wl; v.wd = wd;
    v.ra0 = ra0; v.ra1 = ra1; v.im = im; v.immd = immd; v.mv = mv;
    v.ms = ms; v.cmp = cmp; v.ps = ps; v.pa = pa;
    v.e0 = e0; v.e1 = e1; v.em = em; v.et = et; v.etk = etk; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_full = 1; wr_lane = 0; wr_data = 0;
    rd_addr0 = 0; rd_addr1 = 0; imm = 0; immediate = 0; move = 0;
    mem_sel = 0; cmp_op = 0; pend_set = 0; pend_addr = 0;
  endtask

  initial begin
    // we wa wf wl wd | ra0 ra1 im immd mv | ms cmp ps pa | e0 e1 em target taken stall
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,0,0,0,0, 0,6,0,0, 16'h0000,16'h0000,16'h0000,16'h0000,1,0));
    vecs.push_back(mk(1,2,1,0,16'hABCD, 2,0,0,0,0, 2,0,0,0, 16'hABCD,16'h0000,16'hABCD,16'h0000,0,0));
    vecs.push_back(mk(1,2,0,2,16'h0005, 2,2,0,0,0, 2,7,0,0, 16'hA5CD,16'hA5CD,16'hA5CD,16'h0000,1,0));
    vecs.push_back(mk(1,2,0,3,16'h000F, 2,0,0,0,0, 2,8,0,0, 16'hF5CD,16'h0000,16'hF5CD,16'h0000,1,0));
    vecs.push_back(mk(1,3,1,0,16'h0042, 3,2,0,0,0, 3,4,0,0, 16'h0042,16'hF5CD,16'h0042,16'h0000,0,0));
    vecs.push_back(mk(1,4,1,0,16'h0100, 4,3,0,0,0, 4,6,0,0, 16'h0100,16'h0042,16'h0000,16'h0000,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 4,3,9,1,0, 4,4,0,0, 16'h0009,16'h0000,16'h0000,16'h0100,1,0));
    vecs.push_back(mk(1,1,1,0,16'h0007, 1,1,0,0,1, 1,8,0,0, 16'h0007,16'h0000,16'h0007,16'h0100,1,0));
    vecs.push_back(mk(1,1,1,0,16'h0001, 0,1,0,0,0, 0,4,0,0, 16'h0000,16'h0001,16'h0000,16'h0100,0,0));
    vecs.push_back(mk(1,0,1,0,16'h8000, 0,1,0,0,0, 0,5,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,1,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,4,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,1,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,6,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,7,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,8,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,1,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,0,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,3,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,1,0,0,0, 0,9,0,0, 16'h8000,16'h0001,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,5,0,0,0, 0,0,1,5, 16'h8000,16'h0000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,5,0,0,0, 0,0,0,0, 16'h8000,16'h0000,16'h8000,16'h0100,0,1));
    vecs.push_back(mk(0,0,1,0,16'h0000, 0,5,0,0,1, 0,0,0,0, 16'h8000,16'h0000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 5,0,3,1,0, 0,0,0,0, 16'h0003,16'h0000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 5,0,0,0,0, 0,0,0,0, 16'h0000,16'h8000,16'h8000,16'h0100,0,1));
    vecs.push_back(mk(1,5,1,0,16'h0055, 5,0,0,0,0, 0,4,0,0, 16'h0055,16'h8000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 5,0,0,0,0, 0,0,0,0, 16'h0055,16'h8000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(1,6,1,0,16'h0066, 6,0,0,0,0, 0,0,1,6, 16'h0066,16'h8000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 6,0,0,0,0, 0,0,0,0, 16'h0066,16'h8000,16'h8000,16'h0100,0,1));
    vecs.push_back(mk(1,6,0,0,16'h000A, 6,7,0,0,0, 0,0,1,7, 16'h006A,16'h0000,16'h8000,16'h0100,0,0));
    vecs.push_back(mk(0,0,1,0,16'h0000, 6,7,0,0,0, 0,0,0,0, 16'h006A,16'h0000,16'h8000,16'h0100,0,1));
    vecs.push_back(mk(0,0,1,0,16'h0000, 6,7,0,0,1, 0,0,0,0, 16'h006A,16'h0000,16'h8000,16'h0100,0,0));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_full = vecs[i].wf;
      wr_lane = vecs[i].wl; wr_data = vecs[i].wd;
      rd_addr0 = vecs[i].ra0; rd_addr1 = vecs[i].ra1; imm = vecs[i].im;
      immediate = vecs[i].immd; move = vecs[i].mv; mem_sel = vecs[i].ms;
      cmp_op = vecs[i].cmp; pend_set = vecs[i].ps; pend_addr = vecs[i].pa;
      #2;
      chk($sformatf("v%0d.rd_data0", i), rd_data0, vecs[i].e0);
      chk($sformatf("v%0d.rd_data1", i), rd_data1, vecs[i].e1);
      chk($sformatf("v%0d.mem_data", i), mem_data, vecs[i].em);
      chk($sformatf("v%0d.target", i), target, vecs[i].et);
      chk($sformatf("v%0d.taken", i), 16'(taken), 16'(vecs[i].etk));
      chk($sformatf("v%0d.stall", i), 16'(stall), 16'(vecs[i].est));
    end

    // Asynchronous reset mid-cycle after reg1 = 0x1234, then a write held off by reset.
    @(negedge clk);
    idle_inputs();
    wr_en = 1; wr_addr = 1; wr_data = 16'h1234;
    @(negedge clk);
    idle_inputs();
    rd_addr0 = 1; rd_addr1 = 7;
    #2;
    chk("pre_rst.rd_data0", rd_data0, 16'h1234);
    chk("pre_rst.stall", 16'(stall), 16'h0001);
    rst = 1'b1;
    #1;
    chk("in_rst.rd_data0", rd_data0, 16'h0000);
    chk("in_rst.stall", 16'(stall), 16'h0000);
    chk("in_rst.target", target, 16'h0000);
    chk("in_rst.mem_data", mem_data, 16'h0000);
    wr_en = 1; wr_addr = 1; wr_data = 16'h5555; pend_set = 1; pend_addr = 1;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    rd_addr0 = 1; rd_addr1 = 7;
    #2;
    chk("post_rst.rd_data0", rd_data0, 16'h0000);
    chk("post_rst.stall", 16'(stall), 16'h0000);
    chk("post_rst.target", target, 16'h0000);
    cmp_op = 6;
    #1;
    chk("post_rst.taken_ez", 16'(taken), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
